dec_control: RTL and testbench

Round sequencer for the block-cipher decryption datapath. It is the inverse-direction counterpart of the encryption round controller. Decryption consumes round keys in reverse order, so the block does two things: on a new key it first runs a forward key-expansion pass, then it runs the decryption rounds with a round counter counting down from NR-1 to 0. It uses the same start/act/last/ready/rc handshake as the encryption side, so the top level can drive both cores identically.

---
 rtl/dec_control_pkg.sv | 19 +
 rtl/dec_control_dff.sv | 28 ++
 rtl/dec_control.sv | 128 ++++++++++++
 tb/tb_dec_control.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dec_control_pkg.sv
// -----------------------------------------------------------------------------
// dec_control_pkg
//   Shared definitions for the decryption round sequencer:
//     - state_t     : sequencer state encodings (IDLE / KEXP / DEC)
//     - NR_DEFAULT  : default number of cipher rounds
//     - RCW_DEFAULT : default round-counter width, log2(NR_DEFAULT)
// -----------------------------------------------------------------------------
package dec_control_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    KEXP = 2'b01,
    DEC  = 2'b10
  } state_t;

  localparam int NR_DEFAULT  = 32;
  localparam int RCW_DEFAULT = 5;

endpackage : dec_control_pkg

// File: rtl/dec_control_dff.sv
// -----------------------------------------------------------------------------
// dec_control_dff
//   Parameterised D register with asynchronous active-low clear. Every flop in
//   the sequencer is built from this cell so reset behaviour is uniform.
//   Ports:
//     CK : clock, rising edge
//     RN : asynchronous reset, active low (clears Q to zero)
//     D  : next value, n bits
//     Q  : registered value, n bits
// -----------------------------------------------------------------------------
module dec_control_dff #(
  parameter int n = 1
) (
  input  logic         CK,
  input  logic         RN,
  input  logic [n-1:0] D,
  output logic [n-1:0] Q
);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      Q <= '0;
    end else begin
      Q <= D;
    end
  end

endmodule : dec_control_dff

// File: rtl/dec_control.sv
// -----------------------------------------------------------------------------
// dec_control
//   Round sequencer for the block-cipher decryption datapath. On a new (or
//   never-expanded) key it first runs a forward key-expansion pass with the
//   round counter counting up 0..NR-1, then runs the decryption rounds with the
//   counter counting down NR-1..0. With a cached key it goes straight to the
//   decryption rounds. Handshake matches the encryption round controller.
//   Ports:
//     CK      : clock, rising edge
//     RN      : asynchronous reset, active low
//     start   : one-cycle request to decrypt the block at the datapath input
//     key_new : key changed since last run; only looked at with an accepted start
//     act     : decryption round active this cycle
//     kexp    : key-expansion pass active this cycle
//     last    : final decryption round (act && rc==0), combinational
//     ready   : registered one-cycle pulse, the cycle after last
//     busy    : kexp || act; start is ignored while high
//     rc      : round index to datapath / key schedule
//   Parameters:
//     NR  : number of rounds, power of two, 2..32
//     RCW : round-counter width, log2(NR)
// -----------------------------------------------------------------------------
module dec_control
  import dec_control_pkg::*;
#(
  parameter int NR  = NR_DEFAULT,
  parameter int RCW = RCW_DEFAULT
) (
  input  logic           CK,
  input  logic           RN,
  input  logic           start,
  input  logic           key_new,
  output logic           act,
  output logic           kexp,
  output logic           last,
  output logic           ready,
  output logic           busy,
  output logic [RCW-1:0] rc
);

  localparam logic [RCW-1:0] CNT_MAX = RCW'(NR - 1);

  // Registered state
  logic [1:0]     state_q;
  logic [RCW-1:0] cnt_q;
  logic           key_vld_q;
  logic           ready_q;

  // Next-state values
  logic [1:0]     state_d;
  logic [RCW-1:0] cnt_d;
  logic           key_vld_d;

  // Decoded conditions
  logic is_idle;
  logic is_kexp;
  logic is_dec;
  logic cnt_top;
  logic cnt_zero;
  logic go;
  logic need_kexp;

  assign is_idle  = (state_q == IDLE);
  assign is_kexp  = (state_q == KEXP);
  assign is_dec   = (state_q == DEC);
  assign cnt_top  = (cnt_q == CNT_MAX);
  assign cnt_zero = (cnt_q == '0);

  // A start is only honoured from IDLE; key_new is meaningful only then.
  assign go        = is_idle & start;
  assign need_kexp = key_new | ~key_vld_q;

  // The unused encoding 2'b11 falls back to IDLE with a cleared counter.
  assign state_d = go      ? (need_kexp ? KEXP : DEC) :
                   is_idle ? IDLE :
                   is_kexp ? (cnt_top  ? DEC  : KEXP) :
                   is_dec  ? (cnt_zero ? IDLE : DEC)  :
                             IDLE;

  // Counter loads at the phase boundaries are explicit so the modulo
  // arithmetic never wraps naturally: KEXP hands over at NR-1 straight into
  // DEC at NR-1, and DEC parks at zero on the way back to IDLE.
  assign cnt_d = go      ? (need_kexp ? '0 : CNT_MAX) :
                 is_idle ? cnt_q :
                 is_kexp ? (cnt_top  ? CNT_MAX : cnt_q + 1'b1) :
                 is_dec  ? (cnt_zero ? '0      : cnt_q - 1'b1) :
                           '0;

  // Key becomes valid when an expansion pass completes; only reset clears it.
  assign key_vld_d = key_vld_q | (is_kexp & cnt_top);

  dec_control_dff #(.n(2)) u_state_reg (
    .CK (CK),
    .RN (RN),
    .D  (state_d),
    .Q  (state_q)
  );

  dec_control_dff #(.n(RCW)) u_cnt_reg (
    .CK (CK),
    .RN (RN),
    .D  (cnt_d),
    .Q  (cnt_q)
  );

  dec_control_dff #(.n(1)) u_key_vld_reg (
    .CK (CK),
    .RN (RN),
    .D  (key_vld_d),
    .Q  (key_vld_q)
  );

  dec_control_dff #(.n(1)) u_ready_reg (
    .CK (CK),
    .RN (RN),
    .D  (last),
    .Q  (ready_q)
  );

  // Outputs are decoded straight from registered state.
  assign kexp  = is_kexp;
  assign act   = is_dec;
  assign last  = is_dec & cnt_zero;
  assign busy  = is_kexp | is_dec;
  assign ready = ready_q;
  assign rc    = cnt_q;

endmodule : dec_control

// File: tb/tb_dec_control.sv
// -----------------------------------------------------------------------------
// tb_dec_control
//   Drives an NR=32 and an NR=4 instance from the same stimulus. A per-instance
//   reference model turns each accepted start into the list of per-cycle
//   outputs it should produce and queues them; a per-instance monitor pops and
//   compares one entry every cycle.
// -----------------------------------------------------------------------------
module tb_dec_control;

  typedef struct packed {
    logic       act;
    logic       kexp;
    logic       last;
    logic       ready;
    logic       busy;
    logic [4:0] rc;
  } obs_t;

  logic CK      = 1'b0;
  logic RN      = 1'b1;
  logic start   = 1'b0;
  logic key_new = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CK = ~CK;

  function automatic string fmt(input obs_t o);
    return $sformatf("act=%0b kexp=%0b last=%0b ready=%0b busy=%0b rc=%0d",
                     o.act, o.kexp, o.last, o.ready, o.busy, o.rc);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int NRI  = (gi == 0) ? 32 : 4;
    localparam int RCWI = $clog2(NRI);

    logic            act;
    logic            kexp;
    logic            last;
    logic            ready;
    logic            busy;
    logic [RCWI-1:0] rc;

    obs_t q[$];
    bit   kv = 1'b0;

    dec_control #(.NR(NRI), .RCW(RCWI)) u_dut (
      .CK      (CK),
      .RN      (RN),
      .start   (start),
      .key_new (key_new),
      .act     (act),
      .kexp    (kexp),
      .last    (last),
      .ready   (ready),
      .busy    (busy),
      .rc      (rc)
    );

    // Reference model: a start is taken when nothing remains to be shown
    // after the cycle that just ended (idle or the ready cycle).
    always @(posedge CK) begin
      obs_t r;
      if (RN && start && q.size() == 0) begin
        if (key_new || !kv) begin
          for (int i = 0; i < NRI; i++) begin
            r = '0; r.kexp = 1'b1; r.busy = 1'b1; r.rc = 5'(i);
            q.push_back(r);
          end
        end
        kv = 1'b1;
        for (int i = NRI - 1; i >= 0; i--) begin
          r = '0; r.act = 1'b1; r.busy = 1'b1; r.rc = 5'(i); r.last = (i == 0);
          q.push_back(r);
        end
        r = '0; r.ready = 1'b1;
        q.push_back(r);
      end
    end

    // Monitor: one comparison per cycle against the head of the queue.
    always @(negedge CK) begin
      obs_t got;
      obs_t exp_o;
      got.act = act; got.kexp = kexp; got.last = last;
      got.ready = ready; got.busy = busy; got.rc = 5'(rc);
      if (!RN) begin
        q.delete();
        kv    = 1'b0;
        exp_o = '0;
      end else if (q.size() > 0) begin
        exp_o = q.pop_front();
      end else begin
        exp_o = '0;
      end
      vectors++;
      if (got !== exp_o) begin
        miscompares++;
        $display("FAIL nr%0d_cycle t=%0t got %s expected %s", NRI, $time, fmt(got), fmt(exp_o));
      end
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic wait_ready(input int budget, input string what);
    int n = 0;
    while (!g_inst[0].ready && n < budget) begin
      tick();
      n++;
    end
    if (!g_inst[0].ready) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s got no ready within %0d cycles expected ready", what, budget);
    end
  endtask

  initial begin
    int n;
    obs_t z;

    // Reset
    #2 RN = 1'b0;
    repeat (3) tick();
    RN = 1'b1;
    tick();

    // First start after reset: key expansion forced even with key_new=0
    start = 1'b1; key_new = 1'b0; tick(); start = 1'b0;
    wait_ready(200, "first_run");
    tick(); tick();

    // Cached run with start (and random key_new) held through busy
    start = 1'b1; key_new = 1'b0; tick();
    n = 0;
    while (g_inst[0].busy && n < 100) begin
      start = 1'b1; key_new = 1'($urandom_range(0, 1)); tick(); n++;
    end
    start = 1'b0; key_new = 1'b0;
    tick();

    // Cached run, then new start with key_new=1 in the ready cycle
    start = 1'b1; tick(); start = 1'b0;
    wait_ready(100, "cached_run");
    start = 1'b1; key_new = 1'b1; tick(); start = 1'b0; key_new = 1'b0;
    wait_ready(200, "back_to_back");
    tick();

    // Reset in the middle of DEC at rc=17
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(g_inst[0].act && g_inst[0].rc == 5'd17) && n < 100) begin
      tick(); n++;
    end
    if (!(g_inst[0].act && g_inst[0].rc == 5'd17)) begin
      vectors++; miscompares++;
      $display("FAIL timeout_rc17 got rc=%0d act=%0b expected act at rc=17", g_inst[0].rc, g_inst[0].act);
    end
    RN = 1'b0;
    #1;
    z.act = g_inst[0].act; z.kexp = g_inst[0].kexp; z.last = g_inst[0].last;
    z.ready = g_inst[0].ready; z.busy = g_inst[0].busy; z.rc = g_inst[0].rc;
    vectors++;
    if (z !== '0) begin
      miscompares++;
      $display("FAIL async_reset got %s expected all zero", fmt(z));
    end
    tick(); tick();
    RN = 1'b1;
    tick();
    start = 1'b1; key_new = 1'b0; tick(); start = 1'b0;
    wait_ready(200, "after_reset");
    tick();

    // Random traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      start   = ($urandom_range(0, 5) == 0);
      key_new = 1'($urandom_range(0, 1));
      RN      = ($urandom_range(0, 599) != 0);
      tick();
    end
    RN = 1'b1; start = 1'b0; key_new = 1'b0;
    repeat (150) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dec_control
